// File: rtl/operand_fetch_pkg.sv
// Shared widths and operand-bundle layout for the register-file read path
// (RAM, decode and operand fetch).
package operand_fetch_pkg;

  localparam int unsigned OF_DATA_WIDTH = 16;
  localparam int unsigned OF_ADDR_WIDTH = 8;
  localparam int unsigned OF_OP_WIDTH   = 4;

  typedef struct packed {
    logic [OF_OP_WIDTH-1:0]   opcode;
    logic [OF_ADDR_WIDTH-1:0] dst_addr;
    logic [OF_DATA_WIDTH-1:0] operand1;
    logic [OF_DATA_WIDTH-1:0] operand0;
  } of_bundle_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: request side, RAM read/write-snoop side and execute side.
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = OF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = OF_ADDR_WIDTH,
  parameter int unsigned OP_WIDTH   = OF_OP_WIDTH
);

  logic                  iReqValid;
  logic                  oReqReady;
  logic [ADDR_WIDTH-1:0] iSrcAddr0;
  logic [ADDR_WIDTH-1:0] iSrcAddr1;
  logic [ADDR_WIDTH-1:0] iDstAddr;
  logic [OP_WIDTH-1:0]   iOpcode;
  logic [ADDR_WIDTH-1:0] oReadAddress0;
  logic [ADDR_WIDTH-1:0] oReadAddress1;
  logic [DATA_WIDTH-1:0] iRamData0;
  logic [DATA_WIDTH-1:0] iRamData1;
  logic                  iWriteEnable;
  logic [ADDR_WIDTH-1:0] iWriteAddress;
  logic [DATA_WIDTH-1:0] iWriteData;
  logic                  oOutValid;
  logic                  iOutReady;
  logic [DATA_WIDTH-1:0] oOperand0;
  logic [DATA_WIDTH-1:0] oOperand1;
  logic [ADDR_WIDTH-1:0] oDstAddr;
  logic [OP_WIDTH-1:0]   oOpcode;

  modport master (
    output iReqValid, iSrcAddr0, iSrcAddr1, iDstAddr, iOpcode,
           iRamData0, iRamData1, iWriteEnable, iWriteAddress, iWriteData, iOutReady,
    input  oReqReady, oReadAddress0, oReadAddress1, oOutValid,
           oOperand0, oOperand1, oDstAddr, oOpcode
  );

  modport slave (
    input  iReqValid, iSrcAddr0, iSrcAddr1, iDstAddr, iOpcode,
           iRamData0, iRamData1, iWriteEnable, iWriteAddress, iWriteData, iOutReady,
    output oReqReady, oReadAddress0, oReadAddress1, oOutValid,
           oOperand0, oOperand1, oDstAddr, oOpcode
  );

endinterface

// File: rtl/operand_snoop_reg.sv
// Operand register tagged with its source address; a matching register-file
// write replaces the held data unless a load takes priority.
module operand_snoop_reg
  import operand_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = OF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = OF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  snoop_en,
  input  logic [ADDR_WIDTH-1:0] snoop_addr,
  input  logic [DATA_WIDTH-1:0] snoop_data,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    data_d = data_q;
    addr_d = addr_q;
    if (load) begin
      data_d = load_data;
      addr_d = load_addr;
    end else if (snoop_en && (snoop_addr == addr_q)) begin
      data_d = snoop_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      addr_q <= '0;
    end else begin
      data_q <= data_d;
      addr_q <= addr_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: drives register-file read addresses, captures the
// registered read data and forwards snooped writes into every in-flight operand.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = OF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = OF_ADDR_WIDTH,
  parameter int unsigned OP_WIDTH   = OF_OP_WIDTH
) (
  input logic            Clock,
  input logic            Reset,
  operand_fetch_if.slave bus
);

  logic s2_accept, s1_advance, req_ready, req_accept, s2_held;
  logic [ADDR_WIDTH-1:0] rd_addr0, rd_addr1;
  logic [DATA_WIDTH-1:0] res0, res1, xfer0, xfer1;

  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_addr0_q, s1_addr0_d, s1_addr1_q, s1_addr1_d;
  logic [ADDR_WIDTH-1:0] s1_dst_q, s1_dst_d;
  logic [OP_WIDTH-1:0]   s1_op_q, s1_op_d;
  logic                  s1_fwd0_q, s1_fwd0_d, s1_fwd1_q, s1_fwd1_d;
  logic [DATA_WIDTH-1:0] s1_fwd_data0_q, s1_fwd_data0_d, s1_fwd_data1_q, s1_fwd_data1_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [ADDR_WIDTH-1:0] s2_dst_q, s2_dst_d;
  logic [OP_WIDTH-1:0]   s2_op_q, s2_op_d;

  // Request acceptance is suppressed during reset so the reset cycle's request is dropped.
  always_comb begin
    s2_accept  = !s2_valid_q || bus.iOutReady;
    s1_advance = s1_valid_q && s2_accept;
    req_ready  = !Reset && (!s1_valid_q || s1_advance);
    req_accept = bus.iReqValid && req_ready;
    s2_held    = s2_valid_q && !bus.iOutReady;
    rd_addr0   = req_accept ? bus.iSrcAddr0 : s1_addr0_q;
    rd_addr1   = req_accept ? bus.iSrcAddr1 : s1_addr1_q;
  end

  // RAM data is pre-write, so a same-cycle write seen at read time wins.
  always_comb begin
    res0  = s1_fwd0_q ? s1_fwd_data0_q : bus.iRamData0;
    res1  = s1_fwd1_q ? s1_fwd_data1_q : bus.iRamData1;
    xfer0 = (bus.iWriteEnable && (bus.iWriteAddress == s1_addr0_q)) ? bus.iWriteData : res0;
    xfer1 = (bus.iWriteEnable && (bus.iWriteAddress == s1_addr1_q)) ? bus.iWriteData : res1;
  end

  always_comb begin
    s1_valid_d     = s1_valid_q;
    s1_addr0_d     = s1_addr0_q;
    s1_addr1_d     = s1_addr1_q;
    s1_dst_d       = s1_dst_q;
    s1_op_d        = s1_op_q;
    s1_fwd0_d      = bus.iWriteEnable && (bus.iWriteAddress == rd_addr0);
    s1_fwd1_d      = bus.iWriteEnable && (bus.iWriteAddress == rd_addr1);
    s1_fwd_data0_d = bus.iWriteData;
    s1_fwd_data1_d = bus.iWriteData;
    if (req_accept) begin
      s1_valid_d = 1'b1;
      s1_addr0_d = bus.iSrcAddr0;
      s1_addr1_d = bus.iSrcAddr1;
      s1_dst_d   = bus.iDstAddr;
      s1_op_d    = bus.iOpcode;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_dst_d   = s2_dst_q;
    s2_op_d    = s2_op_q;
    if (s1_advance) begin
      s2_valid_d = 1'b1;
      s2_dst_d   = s1_dst_q;
      s2_op_d    = s1_op_q;
    end else if (bus.iOutReady) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_valid_q     <= 1'b0;
      s1_addr0_q     <= '0;
      s1_addr1_q     <= '0;
      s1_dst_q       <= '0;
      s1_op_q        <= '0;
      s1_fwd0_q      <= 1'b0;
      s1_fwd1_q      <= 1'b0;
      s1_fwd_data0_q <= '0;
      s1_fwd_data1_q <= '0;
      s2_valid_q     <= 1'b0;
      s2_dst_q       <= '0;
      s2_op_q        <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_addr0_q     <= s1_addr0_d;
      s1_addr1_q     <= s1_addr1_d;
      s1_dst_q       <= s1_dst_d;
      s1_op_q        <= s1_op_d;
      s1_fwd0_q      <= s1_fwd0_d;
      s1_fwd1_q      <= s1_fwd1_d;
      s1_fwd_data0_q <= s1_fwd_data0_d;
      s1_fwd_data1_q <= s1_fwd_data1_d;
      s2_valid_q     <= s2_valid_d;
      s2_dst_q       <= s2_dst_d;
      s2_op_q        <= s2_op_d;
    end
  end

  operand_snoop_reg #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_operand0 (
    .clk        (Clock),
    .rst        (Reset),
    .load       (s1_advance),
    .load_data  (xfer0),
    .load_addr  (s1_addr0_q),
    .snoop_en   (s2_held && bus.iWriteEnable),
    .snoop_addr (bus.iWriteAddress),
    .snoop_data (bus.iWriteData),
    .data       (bus.oOperand0)
  );

  operand_snoop_reg #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_operand1 (
    .clk        (Clock),
    .rst        (Reset),
    .load       (s1_advance),
    .load_data  (xfer1),
    .load_addr  (s1_addr1_q),
    .snoop_en   (s2_held && bus.iWriteEnable),
    .snoop_addr (bus.iWriteAddress),
    .snoop_data (bus.iWriteData),
    .data       (bus.oOperand1)
  );

  assign bus.oReqReady     = req_ready;
  assign bus.oReadAddress0 = rd_addr0;
  assign bus.oReadAddress1 = rd_addr1;
  assign bus.oOutValid     = s2_valid_q;
  assign bus.oDstAddr      = s2_dst_q;
  assign bus.oOpcode       = s2_op_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch with a pre-write registered-read RAM model.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  localparam int unsigned DW = OF_DATA_WIDTH;
  localparam int unsigned AW = OF_ADDR_WIDTH;
  localparam int unsigned OW = OF_OP_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_WIDTH(OW)) bus ();

  operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_WIDTH(OW)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  logic [DW-1:0] mem [0:255];

  always @(posedge clk) begin
    bus.iRamData0 <= mem[bus.oReadAddress0];
    bus.iRamData1 <= mem[bus.oReadAddress1];
    if (bus.iWriteEnable) mem[bus.iWriteAddress] <= bus.iWriteData;
  end

  int checks = 0;
  int errors = 0;
  of_bundle_t sb[$];
  int unsigned xfers = 0;
  int unsigned run_len = 0;
  int unsigned max_run = 0;
  bit toggle_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [AW-1:0] s0, input logic [AW-1:0] s1, input logic [AW-1:0] d,
                       input logic [OW-1:0] op, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                       input bit push);
    int unsigned n;
    of_bundle_t b;
    n = 0;
    bus.iReqValid = 1'b1;
    bus.iSrcAddr0 = s0;
    bus.iSrcAddr1 = s1;
    bus.iDstAddr  = d;
    bus.iOpcode   = op;
    @(negedge clk);
    while (!bus.oReqReady && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.oReqReady) begin
      errors++;
      $display("FAIL accept_timeout actual=ready0 required=ready1 src0=%h", s0);
    end else if (push) begin
      b.opcode = op; b.dst_addr = d; b.operand0 = e0; b.operand1 = e1;
      sb.push_back(b);
    end
    @(posedge clk); #1;
    bus.iReqValid    = 1'b0;
    bus.iWriteEnable = 1'b0;
  endtask

  // Monitor: pops on every completed output transfer, and checks held bundles stay put.
  logic            held_prev = 1'b0;
  logic [AW-1:0]   held_dst;
  logic [OW-1:0]   held_op;
  always @(negedge clk) begin
    of_bundle_t exp, got;
    if (!rst) begin
      if (held_prev) begin
        checks++;
        if (!(bus.oOutValid === 1'b1 && bus.oDstAddr === held_dst && bus.oOpcode === held_op)) begin
          errors++;
          $display("FAIL hold_stable actual=v%b d%h o%h required=v1 d%h o%h",
                   bus.oOutValid, bus.oDstAddr, bus.oOpcode, held_dst, held_op);
        end
      end
      if (bus.oOutValid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else run_len = 0;
      if (bus.oOutValid === 1'b1 && bus.iOutReady === 1'b1) begin
        xfers++;
        checks++;
        got.opcode = bus.oOpcode; got.dst_addr = bus.oDstAddr;
        got.operand0 = bus.oOperand0; got.operand1 = bus.oOperand1;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bundle actual=%h required=none", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL bundle actual=%h required=%h", got, exp);
          end
        end
      end
    end
    held_prev = !rst && bus.oOutValid === 1'b1 && bus.iOutReady === 1'b0;
    held_dst  = bus.oDstAddr;
    held_op   = bus.oOpcode;
  end

  always @(posedge clk) begin
    if (toggle_en) begin
      #1;
      bus.iOutReady = ~bus.iOutReady;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] v_s0 [0:2];
    logic [AW-1:0] v_s1 [0:2];
    logic [AW-1:0] v_d  [0:2];
    logic [OW-1:0] v_op [0:2];
    logic [DW-1:0] v_e0 [0:2];
    logic [DW-1:0] v_e1 [0:2];
    int unsigned k, acc, x0;
    of_bundle_t b;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[3] = 16'h1111;
    mem[5] = 16'h2222;
    for (int i = 0; i < 8; i++) begin
      mem[8'h20 + i] = 16'h2000 + 16'(i);
      mem[8'h30 + i] = 16'h3000 + 16'(i);
    end
    bus.iReqValid = 0; bus.iSrcAddr0 = '0; bus.iSrcAddr1 = '0; bus.iDstAddr = '0;
    bus.iOpcode = '0; bus.iWriteEnable = 0; bus.iWriteAddress = '0; bus.iWriteData = '0;
    bus.iOutReady = 1;

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid", 32'(bus.oOutValid), 0);
    chk("rst_ready", 32'(bus.oReqReady), 1);
    chk("rst_operands", {bus.oOperand0, bus.oOperand1}, 0);
    chk("rst_dst_op", {bus.oDstAddr, bus.oOpcode}, 0);
    chk("rst_rdaddr", {bus.oReadAddress0, bus.oReadAddress1}, 0);
    @(posedge clk); #1;

    // single request and latency
    issue(8'd3, 8'd5, 8'h11, 4'h1, 16'h1111, 16'h2222, 1);
    @(negedge clk);
    chk("latency_s1", 32'(bus.oOutValid), 0);
    @(negedge clk);
    chk("latency_s2", 32'(bus.oOutValid), 1);
    @(posedge clk); #1;

    // write in the accept cycle
    bus.iWriteEnable = 1; bus.iWriteAddress = 8'd7; bus.iWriteData = 16'hBEEF;
    issue(8'd7, 8'd5, 8'h22, 4'h2, 16'hBEEF, 16'h2222, 1);
    // write one cycle after accept
    issue(8'd7, 8'd5, 8'h33, 4'h3, 16'hCAFE, 16'h2222, 1);
    bus.iWriteEnable = 1; bus.iWriteAddress = 8'd7; bus.iWriteData = 16'hCAFE;
    @(posedge clk); #1;
    bus.iWriteEnable = 0;
    // both operands on one address, written in the accept cycle
    bus.iWriteEnable = 1; bus.iWriteAddress = 8'h40; bus.iWriteData = 16'h7777;
    issue(8'h40, 8'h40, 8'h44, 4'h4, 16'h7777, 16'h7777, 1);
    repeat (4) @(posedge clk); #1;

    // stall with a write to the held source address
    v_s0[0] = 8'd3; v_s1[0] = 8'd9; v_d[0] = 8'h55; v_op[0] = 4'h5; v_e0[0] = 16'h1111; v_e1[0] = 16'h1234;
    v_s0[1] = 8'd5; v_s1[1] = 8'd3; v_d[1] = 8'h66; v_op[1] = 4'h6; v_e0[1] = 16'h2222; v_e1[1] = 16'h1111;
    v_s0[2] = 8'd5; v_s1[2] = 8'd5; v_d[2] = 8'h77; v_op[2] = 4'h7; v_e0[2] = 16'h2222; v_e1[2] = 16'h2222;
    bus.iOutReady = 0;
    k = 0; acc = 0;
    for (int c = 0; c < 5; c++) begin
      bus.iReqValid = (k < 3);
      if (k < 3) begin
        bus.iSrcAddr0 = v_s0[k]; bus.iSrcAddr1 = v_s1[k]; bus.iDstAddr = v_d[k]; bus.iOpcode = v_op[k];
      end
      bus.iWriteEnable = (c == 3); bus.iWriteAddress = 8'd9; bus.iWriteData = 16'h1234;
      @(negedge clk);
      if (c == 3) chk("stall_pre_write", 32'(bus.oOperand1), 0);
      if (c == 4) chk("stall_snoop", 32'(bus.oOperand1), 32'h1234);
      if (bus.iReqValid && bus.oReqReady) begin
        b.opcode = v_op[k]; b.dst_addr = v_d[k]; b.operand0 = v_e0[k]; b.operand1 = v_e1[k];
        sb.push_back(b);
        k++; acc++;
      end
      @(posedge clk); #1;
    end
    bus.iWriteEnable = 0;
    chk("stall_accepts", acc, 2);
    bus.iOutReady = 1;
    if (k == 2) issue(v_s0[2], v_s1[2], v_d[2], v_op[2], v_e0[2], v_e1[2], 1);
    else bus.iReqValid = 0;
    repeat (5) @(posedge clk); #1;

    // back-to-back burst
    max_run = 0;
    for (int i = 0; i < 8; i++)
      issue(8'h20 + 8'(i), 8'h37 - 8'(i), 8'(i), 4'(i), 16'h2000 + 16'(i), 16'h3007 - 16'(i), 1);
    repeat (5) @(posedge clk); #1;
    chk("burst_consecutive", max_run, 8);

    // toggling backpressure
    x0 = xfers;
    toggle_en = 1;
    for (int i = 0; i < 8; i++)
      issue(8'h30 + 8'(i), 8'h20 + 8'(i), 8'h80 + 8'(i), 4'(15 - i), 16'h3000 + 16'(i), 16'h2000 + 16'(i), 1);
    toggle_en = 0;
    @(posedge clk); #2;
    bus.iOutReady = 1;
    repeat (6) @(posedge clk); #1;
    chk("toggle_count", xfers - x0, 8);
    chk("toggle_drained", sb.size(), 0);

    // reset with both stages full
    bus.iOutReady = 0;
    issue(8'd3, 8'd5, 8'hA1, 4'hA, 16'h1111, 16'h2222, 0);
    issue(8'd5, 8'd3, 8'hA2, 4'hB, 16'h2222, 16'h1111, 0);
    rst = 1;
    bus.iReqValid = 1; bus.iSrcAddr0 = 8'd3; bus.iSrcAddr1 = 8'd3; bus.iDstAddr = 8'hA3; bus.iOpcode = 4'hC;
    @(negedge clk);
    chk("full_before_reset", 32'(bus.oOutValid), 1);
    @(posedge clk); #1;
    rst = 0;
    bus.iReqValid = 0;
    bus.iOutReady = 1;
    x0 = xfers;
    @(negedge clk);
    chk("post_reset_valid", 32'(bus.oOutValid), 0);
    chk("post_reset_ready", 32'(bus.oReqReady), 1);
    repeat (6) @(posedge clk); #1;
    chk("post_reset_no_output", xfers - x0, 0);
    chk("final_queue_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
